sko_seg_decoder: RTL and testbench
==================================

# sko_seg_decoder

Receives a stream of active-low seven-segment patterns and recovers the marquee character codes (G=0 … END2=9) used by the "GO BUFFS" display path. It is the inverse of the character-to-segment encoder. Ambiguous patterns are resolved by a small context state machine: F1/F2 share a pattern, and SPACE/END1/END2 share a pattern. Decoded codes are buffered in a small FIFO with valid/ready on both sides. It sits between a segment capture source (board loopback or test harness) and any consumer of message character indices.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- seg_in  in  7  active-low segment pattern, bit 6 = g … bit 0 = a
- seg_valid  in  1  seg_in holds a pattern
- seg_ready  out  1  decoder can accept this cycle
- char_out  out  4  character code at FIFO head
- char_valid  out  1  char_out valid
- char_ready  in  1  consumer takes char_out this cycle
- err  out  1  one-cycle pulse: unknown pattern accepted
- err_cnt  out  8  saturating count of unknown patterns

## Operation
- Input transfer: seg_valid & seg_ready on a rising edge. Output transfer: char_valid & char_ready.
- Pattern map for an accepted transfer:
  - 1000010 → G(0)
  - 1000000 → O(1)
  - 0000011 → B(3)
  - 1000001 → U(4)
  - 0010010 → S(7)
  - 0001110 → F2(6) if state is AFTER_F, else F1(5)
  - 1111111 → END1(8) if AFTER_S, END2(9) if AFTER_END1, else SPACE(2)
  - Anything else is unknown: nothing is pushed, err pulses, err_cnt += 1 (saturates at 255).
- Context FSM states: NORM, AFTER_F, AFTER_S, AFTER_END1. Reset state is NORM. It changes only on accepted input transfers:
  - F1 → AFTER_F
  - S → AFTER_S
  - END1 → AFTER_END1
  - all other codes (including F2, END2 and SPACE) and unknown patterns → NORM
  - So FFF decodes as F1 F2 F1, and S followed by three blanks decodes as S END1 END2 SPACE.
- FIFO behaviour:
  - A decoded code is written at the tail on the accepting edge.
  - char_out is the head entry. A pop advances the head.
  - seg_ready = (count < DEPTH). It is a function of registered count only and does not depend on char_ready in the same cycle.
  - char_valid = (count != 0).
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged, and both pointers advance with wrap modulo DEPTH.
- Push of an unknown pattern: the cycle counts as an accepted input but does not count as a push.

## Timing
- Reset values: seg_ready=1, char_valid=0, char_out=0 (storage cleared), err=0, err_cnt=0, FSM=NORM, pointers=0.
- Reset mid-stream discards all buffered codes and context immediately (asynchronous assertion). Release is synchronous to clk.
- Latency: a code accepted at edge N is visible on char_out/char_valid after edge N. It can be popped at edge N+1.
- err is asserted for exactly the cycle after the accepting edge of an unknown pattern.
- Full FIFO: seg_ready=0. Upstream must hold its pattern, and FSM state does not advance. A pop at edge N raises seg_ready after edge N.
- Empty FIFO: char_ready is ignored and pointers do not move.
- Throughput: one code per cycle sustained when char_ready is held high.

## Structure
- Shared package sko_char_pkg holds:
  - character code constants G…END2 as 4-bit localparams, shared with the encoder
  - the seven segment-pattern constants
  - the context state enum
- Sub-module sko_sync_fifo, parameterised by width 4 and DEPTH. It has push/pop/full/empty/count and asynchronous active-low reset. Its clock and reset ports are clk/rst_n.
- The decode table plus FSM live in the top module.

## Test plan
- Stream the patterns for G,O,blank,B,U,F,F,S,blank,blank with char_ready=1. Required output: 0,1,2,3,4,5,6,7,8,9, and err never asserts.
- Send three consecutive F patterns, then U, then F. Required output: 5,6,5,4,5.
- Hold char_ready=0 and push 5 patterns with DEPTH=4. Required: seg_ready drops after the 4th accept, and the 5th pattern is held. Then release char_ready. Required: output order is preserved, and the 5th code is decoded with the context of the 4th.
- Send 0110000. Required: err pulses for one cycle, err_cnt=1, nothing is queued, and the context returns to NORM. Then send 256 more unknown patterns. Required: err_cnt stays at 255.
- Send S, then assert rst_n=0 for one cycle while the FIFO is half full, then send blank. Required: FIFO empty after reset, and the blank decodes as SPACE(2), not END1.
- With count=2, push and pop on the same edge. Required: count stays at 2, and head/tail wrap correctly across 8 such cycles.

Source files
------------

// File: rtl/sko_char_pkg.sv
// ---------------------------------------------------------------------------
// sko_char_pkg
// Shared definitions for the "GO BUFFS" marquee character path.
//   - 4-bit character codes (G=0 ... END2=9), common to encoder and decoder
//   - active-low seven-segment patterns, bit 6 = g ... bit 0 = a
//   - context state enum used to disambiguate shared segment patterns
// ---------------------------------------------------------------------------
package sko_char_pkg;

  localparam logic [3:0] CH_G     = 4'd0;
  localparam logic [3:0] CH_O     = 4'd1;
  localparam logic [3:0] CH_SPACE = 4'd2;
  localparam logic [3:0] CH_B     = 4'd3;
  localparam logic [3:0] CH_U     = 4'd4;
  localparam logic [3:0] CH_F1    = 4'd5;
  localparam logic [3:0] CH_F2    = 4'd6;
  localparam logic [3:0] CH_S     = 4'd7;
  localparam logic [3:0] CH_END1  = 4'd8;
  localparam logic [3:0] CH_END2  = 4'd9;

  // F1/F2 share SEG_F; SPACE/END1/END2 share SEG_BLANK (all segments off)
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CTX_NORM,
    CTX_AFTER_F,
    CTX_AFTER_S,
    CTX_AFTER_END1
  } ctx_t;

endpackage

// File: rtl/sko_sync_fifo.sv
// ---------------------------------------------------------------------------
// sko_sync_fifo
// Single-clock FIFO with registered occupancy count.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (clears storage and pointers)
//   push   in   write din at tail (ignored when full)
//   din    in   WIDTH-bit write data
//   pop    in   advance head (ignored when empty)
//   dout   out  head entry
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sko_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sko_seg_decoder.sv
// ---------------------------------------------------------------------------
// sko_seg_decoder
// Recovers marquee character codes from active-low seven-segment patterns.
// A context FSM resolves the shared F and blank patterns; decoded codes are
// queued in a small FIFO with valid/ready on both sides.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   seg_in     in   active-low segment pattern (bit 6 = g ... bit 0 = a)
//   seg_valid  in   seg_in holds a pattern
//   seg_ready  out  decoder can accept (FIFO not full)
//   char_out   out  code at FIFO head
//   char_valid out  char_out valid (FIFO not empty)
//   char_ready in   consumer takes char_out
//   err        out  one-cycle pulse after an unknown pattern is accepted
//   err_cnt    out  saturating count of unknown patterns
// ---------------------------------------------------------------------------
module sko_seg_decoder
  import sko_char_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic       seg_ready,
  output logic [3:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          known;
  logic [3:0]    code;
  ctx_t          ctx;
  ctx_t          ctx_next;

  // Handshakes depend only on registered FIFO state, never on char_ready
  assign seg_ready  = ~full;
  assign char_valid = (count != '0);
  assign accept     = seg_valid & seg_ready;
  assign push       = accept & known;
  assign pop        = char_ready & ~empty;

  // Decode table; ctx_next defaults to NORM so unknown patterns clear context
  always_comb begin
    known    = 1'b1;
    code     = CH_G;
    ctx_next = CTX_NORM;
    case (seg_in)
      SEG_G: code = CH_G;
      SEG_O: code = CH_O;
      SEG_B: code = CH_B;
      SEG_U: code = CH_U;
      SEG_S: begin
        code     = CH_S;
        ctx_next = CTX_AFTER_S;
      end
      SEG_F: begin
        if (ctx == CTX_AFTER_F) begin
          code = CH_F2;
        end else begin
          code     = CH_F1;
          ctx_next = CTX_AFTER_F;
        end
      end
      SEG_BLANK: begin
        case (ctx)
          CTX_AFTER_S: begin
            code     = CH_END1;
            ctx_next = CTX_AFTER_END1;
          end
          CTX_AFTER_END1: code = CH_END2;
          default:        code = CH_SPACE;
        endcase
      end
      default: known = 1'b0;
    endcase
  end

  // Context and error state advance only on accepted input transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx     <= CTX_NORM;
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= accept & ~known;
      if (accept) begin
        ctx <= ctx_next;
      end
      if (accept && !known && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  sko_sync_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (code),
    .pop   (pop),
    .dout  (char_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_sko_seg_decoder.sv
// ---------------------------------------------------------------------------
// tb_sko_seg_decoder
// Directed-vector bench for sko_seg_decoder (DEPTH=4). Inputs are driven 1ns
// after the rising edge; a monitor samples handshakes on the falling edge and
// records every popped code for comparison with hand-computed sequences.
// ---------------------------------------------------------------------------
module tb_sko_seg_decoder;

  localparam logic [6:0] P_G     = 7'b1000010;
  localparam logic [6:0] P_O     = 7'b1000000;
  localparam logic [6:0] P_B     = 7'b0000011;
  localparam logic [6:0] P_U     = 7'b1000001;
  localparam logic [6:0] P_S     = 7'b0010010;
  localparam logic [6:0] P_F     = 7'b0001110;
  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_BAD1  = 7'b0110000;
  localparam logic [6:0] P_BAD2  = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic       seg_ready;
  logic [3:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       err;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int err_pulses = 0;
  int got_q[$];
  int exp_q[$];

  sko_seg_decoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Record every output transfer and every err pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid && char_ready) got_q.push_back(int'(char_out));
      if (err) err_pulses++;
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one pattern and hold it until accepted (bounded wait)
  task automatic applyStimulus(input logic [6:0] p);
    int waited = 0;
    seg_in    = p;
    seg_valid = 1'b1;
    @(negedge clk);
    while (!seg_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!seg_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic drain();
    char_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic checkQueue(input string tag);
    checkOutput($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checkOutput($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    seg_in     = '0;
    seg_valid  = 1'b0;
    char_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_seg_ready", int'(seg_ready), 1);
    checkOutput("rst_char_valid", int'(char_valid), 0);
    checkOutput("rst_char_out", int'(char_out), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_err_cnt", int'(err_cnt), 0);

    // Full message stream at one code per cycle
    @(posedge clk);
    #1;
    char_ready = 1'b1;
    applyStimulus(P_G);
    applyStimulus(P_O);
    applyStimulus(P_BLANK);
    applyStimulus(P_B);
    applyStimulus(P_U);
    applyStimulus(P_F);
    applyStimulus(P_F);
    applyStimulus(P_S);
    applyStimulus(P_BLANK);
    applyStimulus(P_BLANK);
    drain();
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    checkQueue("msg");

    // Alternating F context
    applyStimulus(P_F);
    applyStimulus(P_F);
    applyStimulus(P_F);
    applyStimulus(P_U);
    applyStimulus(P_F);
    drain();
    exp_q = '{5, 6, 5, 4, 5};
    checkQueue("fff");

    // Back-pressure: fill, hold 5th, then release
    char_ready = 1'b0;
    applyStimulus(P_G);
    applyStimulus(P_O);
    applyStimulus(P_F);
    applyStimulus(P_S);
    @(negedge clk);
    checkOutput("full_seg_ready", int'(seg_ready), 0);
    checkOutput("full_char_valid", int'(char_valid), 1);
    checkOutput("full_head", int'(char_out), 0);
    @(posedge clk);
    #1;
    seg_in    = P_BLANK;
    seg_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("held_seg_ready", int'(seg_ready), 0);
    checkOutput("held_no_pop", got_q.size(), 0);
    @(posedge clk);
    #1;
    char_ready = 1'b1;
    applyStimulus(P_BLANK);
    drain();
    exp_q = '{0, 1, 5, 7, 8};
    checkQueue("bp");
    checkOutput("no_err_pulses", err_pulses, 0);

    // Unknown pattern: err pulse, counter, context cleared
    applyStimulus(P_F);
    applyStimulus(P_BAD1);
    @(negedge clk);
    checkOutput("unk_err_hi", int'(err), 1);
    checkOutput("unk_err_cnt", int'(err_cnt), 1);
    checkOutput("unk_not_queued", int'(char_valid), 0);
    @(negedge clk);
    checkOutput("unk_err_lo", int'(err), 0);
    @(posedge clk);
    #1;
    applyStimulus(P_F);
    drain();
    exp_q = '{5, 5};
    checkQueue("unk_ctx");
    checkOutput("unk_pulses", err_pulses, 1);

    // Saturation
    for (int i = 0; i < 254; i++) applyStimulus((i % 2) ? P_BAD2 : P_BAD1);
    @(negedge clk);
    checkOutput("sat_reach", int'(err_cnt), 255);
    @(posedge clk);
    #1;
    applyStimulus(P_BAD1);
    applyStimulus(P_BAD2);
    @(negedge clk);
    checkOutput("sat_hold", int'(err_cnt), 255);
    checkOutput("sat_empty", int'(char_valid), 0);

    // Mid-stream reset discards queue and context
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    applyStimulus(P_S);
    applyStimulus(P_G);
    @(negedge clk);
    checkOutput("pre_rst_valid", int'(char_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_char_valid", int'(char_valid), 0);
    checkOutput("arst_seg_ready", int'(seg_ready), 1);
    checkOutput("arst_char_out", int'(char_out), 0);
    checkOutput("arst_err_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    char_ready = 1'b1;
    applyStimulus(P_BLANK);
    drain();
    exp_q = '{2};
    checkQueue("post_rst");

    // Simultaneous push/pop at count=2 across pointer wrap
    char_ready = 1'b0;
    applyStimulus(P_G);
    applyStimulus(P_O);
    begin
      logic [6:0] pats [8];
      pats = '{P_B, P_U, P_S, P_G, P_O, P_B, P_U, P_G};
      char_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        seg_in    = pats[i];
        seg_valid = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("pp_ready_%0d", i), int'(seg_ready), 1);
        checkOutput($sformatf("pp_valid_%0d", i), int'(char_valid), 1);
        @(posedge clk);
        #1;
      end
      seg_valid  = 1'b0;
      char_ready = 1'b0;
    end
    checkOutput("pp_pops", got_q.size(), 8);
    drain();
    exp_q = '{0, 1, 3, 4, 7, 0, 1, 3, 4, 0};
    checkQueue("pp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
